final_tcp_hw_button_in: RTL and testbench

//  Avalon-MM slave input port: the read-side counterpart of the LED output PIO on the same system bus.

---
 rtl/final_tcp_hw_button_in.sv | 136 +++++++++++++
 tb/tb_final_tcp_hw_button_in.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/final_tcp_hw_button_in.sv
// final_tcp_hw_button_in
//   Avalon-MM slave input port for push-buttons and switches. It is the read-side
//   counterpart of the LED output PIO on the same bus. Each raw input bit passes
//   through a 2-flop synchronizer and a per-bit debouncer. Edges of the debounced
//   value are captured into a write-1-to-clear register. A level interrupt is
//   raised while any captured edge is unmasked.
//
//   Register map (word address):
//     0 DATA       RO     debounced value
//     1 DIRECTION  RO     always 0 (input-only port)
//     2 IRQ_MASK   RW     interrupt mask
//     3 EDGE_CAP   R/W1C  captured edges; writing 1 to a bit clears it
//
// Ports
//   clk         system clock, all logic on posedge
//   reset       synchronous, active-high
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe (chipselect & write_n is a read)
//   writedata   write data
//   in_port     raw asynchronous inputs
//   readdata    registered read data, one-cycle read latency
//   irq         high while any (edge_capture & irq_mask) bit is set
module final_tcp_hw_button_in #(
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      DEBOUNCE  = 50000,
  parameter int unsigned      EDGE_TYPE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned      CNT_W  = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_ECAP = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdmux;
  logic             w_unused_wdata;

  assign w_wr = chipselect & ~write_n;
  assign w_rd = chipselect & write_n;

  // Synchronizer and per-bit debounce. A bit only moves once the synchronized
  // input has disagreed with it for DEBOUNCE consecutive cycles; any agreement
  // in between restarts the count from zero, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
      r_db    <= RESET_VAL;
      r_prev  <= RESET_VAL;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= r_db;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_TC) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_rise = r_db & ~r_prev;
  assign w_fall = ~r_db & r_prev;
  assign w_ev   = (EDGE_TYPE == 0) ? w_rise :
                  (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);

  assign w_clr = (w_wr && (address == ADDR_ECAP)) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_rdmux = '0;
    case (address)
      ADDR_DATA: w_rdmux[WIDTH-1:0] = r_db;
      ADDR_MASK: w_rdmux[WIDTH-1:0] = r_irq_mask;
      ADDR_ECAP: w_rdmux[WIDTH-1:0] = r_edge_cap;
      default:   w_rdmux = '0;
    endcase
  end

  // A new edge in the same cycle as a clear of that bit wins, so no edge is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_readdata <= '0;
    end else begin
      if (w_wr && (address == ADDR_MASK)) begin
        r_irq_mask <= writedata[WIDTH-1:0];
      end
      r_edge_cap <= w_ev | (r_edge_cap & ~w_clr);
      r_readdata <= w_rd ? w_rdmux : 32'd0;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge_cap & r_irq_mask);

  // Upper write-data bits have no destination when WIDTH < 32.
  assign w_unused_wdata = &{1'b0, writedata};

endmodule

// File: tb/tb_final_tcp_hw_button_in.sv
// Testbench for final_tcp_hw_button_in. Two instances share all inputs: one with
// rising-edge capture and reset value 0, one with any-edge capture and reset
// value 4'h5. A reference model predicts readdata and irq for both every cycle;
// directed steps add constant checks on the key behaviours.
module tb_final_tcp_hw_button_in;

  localparam int         D   = 8;
  localparam logic [3:0] RV0 = 4'h0;
  localparam logic [3:0] RV1 = 4'h5;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd_r;
  logic [31:0] rd_a;
  logic        irq_r;
  logic        irq_a;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: raw input history (one entry per clock edge) and the
  // architecturally visible registers of each instance.
  logic [3:0]  h_in [$];
  bit          h_rst [$];
  logic [3:0]  m_db   [2];
  logic [3:0]  m_prev [2];
  logic [3:0]  m_cap  [2];
  logic [31:0] m_rd   [2];
  logic [3:0]  m_mask;

  final_tcp_hw_button_in #(
    .WIDTH(4), .DEBOUNCE(D), .EDGE_TYPE(0), .RESET_VAL(RV0)
  ) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r)
  );

  final_tcp_hw_button_in #(
    .WIDTH(4), .DEBOUNCE(D), .EDGE_TYPE(2), .RESET_VAL(RV1)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [3:0] rv(input int d);
    return (d == 0) ? RV0 : RV1;
  endfunction

  // Synchronized view of the input as seen j edges into the history.
  function automatic logic [3:0] samp(input int d, input int j);
    if (j < 0) return rv(d);
    if (h_rst[j]) return rv(d);
    return h_in[j];
  endfunction

  function automatic logic [31:0] regval(input int d, input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_db[d]};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, m_cap[d]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: predict next model state from current inputs, take the
  // edge, commit and compare both instances.
  task automatic tick();
    logic [3:0]  n_db [2];
    logic [3:0]  n_prev [2];
    logic [3:0]  n_cap [2];
    logic [31:0] n_rd [2];
    logic [3:0]  n_mask, clr, ev, rise, fall, s;
    logic        x, ok;
    int          n;
    h_in.push_back(in_port);
    h_rst.push_back(reset);
    n = h_in.size() - 1;
    clr    = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
    n_mask = reset ? 4'h0 :
             ((chipselect && !write_n && address == 2'd2) ? writedata[3:0] : m_mask);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        n_db[d] = rv(d); n_prev[d] = rv(d); n_cap[d] = 4'h0; n_rd[d] = 32'd0;
      end else begin
        // A bit takes a new value once the last D synchronized samples all agree on it.
        n_db[d] = m_db[d];
        for (int b = 0; b < 4; b++) begin
          s  = samp(d, n - 2);
          x  = s[b];
          ok = (x != m_db[d][b]);
          for (int k = 0; k < D; k++) begin
            s = samp(d, n - 2 - k);
            if (s[b] != x) ok = 1'b0;
          end
          if (ok) n_db[d][b] = x;
        end
        n_prev[d] = m_db[d];
        rise = m_db[d] & ~m_prev[d];
        fall = ~m_db[d] & m_prev[d];
        ev   = (d == 0) ? rise : (rise | fall);
        n_cap[d] = ev | (m_cap[d] & ~clr);
        n_rd[d]  = (chipselect && write_n) ? regval(d, address) : 32'd0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_db[d] = n_db[d]; m_prev[d] = n_prev[d]; m_cap[d] = n_cap[d]; m_rd[d] = n_rd[d];
    end
    m_mask = n_mask;
    check("model_rdata_r", rd_r, m_rd[0]);
    check("model_rdata_a", rd_a, m_rd[1]);
    check("model_irq_r", {31'd0, irq_r}, {31'd0, |(m_cap[0] & m_mask)});
    check("model_irq_a", {31'd0, irq_a}, {31'd0, |(m_cap[1] & m_mask)});
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    tick();
    chipselect = 1'b0;
  endtask

  initial begin
    logic [3:0] tmp;
    int         bit_sel;
    for (int d = 0; d < 2; d++) begin
      m_db[d] = rv(d); m_prev[d] = rv(d); m_cap[d] = 4'h0; m_rd[d] = 32'd0;
    end
    m_mask     = 4'h0;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 4'hF;

    // Reset with all inputs high, then watch DATA settle at exactly 2+D edges.
    ticks(3);
    reset = 1'b0;
    check("t1_irq_rst", {31'd0, irq_r}, 32'd0);
    bus_read(2'd0);
    check("t1_data_rst", rd_r, 32'h0);
    ticks(7);
    bus_read(2'd0);
    check("t1_data_e9", rd_r, 32'h0);
    bus_read(2'd0);
    check("t1_data_e10", rd_r, 32'h0);
    bus_read(2'd0);
    check("t1_data_e11", rd_r, 32'hF);
    bus_read(2'd3);
    check("t1_cap_rise", rd_r, 32'hF);
    check("t1_cap_any", rd_a, 32'hA);
    check("t1_irq_masked", {31'd0, irq_r}, 32'd0);
    bus_write(2'd1, 32'hF);
    bus_read(2'd1);
    check("t1_dir_ro", rd_r, 32'h0);

    // Short glitch on bit0 is rejected; a long hold is accepted at 2+D.
    in_port = 4'h0;
    ticks(12);
    bus_write(2'd3, 32'hF);
    in_port = 4'h1;
    ticks(5);
    in_port = 4'h0;
    ticks(12);
    bus_read(2'd0);
    check("t2_glitch_data", rd_r, 32'h0);
    bus_read(2'd3);
    check("t2_glitch_cap", rd_r, 32'h0);
    in_port = 4'h1;
    ticks(9);
    bus_read(2'd0);
    check("t2_hold_e10", rd_r, 32'h0);
    bus_read(2'd0);
    check("t2_hold_e11", rd_r, 32'h1);

    // Masked interrupt on bit1, W1C clear, unmasked bit0 edge.
    bus_write(2'd2, 32'h2);
    in_port = 4'h3;
    ticks(10);
    check("t3_irq_before", {31'd0, irq_r}, 32'd0);
    tick();
    check("t3_irq_set", {31'd0, irq_r}, 32'd1);
    bus_write(2'd3, 32'h2);
    check("t3_irq_cleared", {31'd0, irq_r}, 32'd0);
    bus_write(2'd3, 32'hF);
    in_port = 4'h2;
    ticks(12);
    in_port = 4'h3;
    ticks(12);
    bus_read(2'd3);
    check("t3_cap_bit0", rd_r, 32'h1);
    check("t3_irq_unmasked_bit", {31'd0, irq_r}, 32'd0);

    // Clear of bit2 coinciding with a new bit2 edge: the edge survives.
    in_port = 4'h7;
    ticks(10);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3);
    check("t4_set_wins", rd_r, 32'h5);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3);
    check("t4_clear_after", rd_r, 32'h1);

    // Any-edge capture on bit3: rise, clear, fall re-sets it.
    bus_write(2'd3, 32'hF);
    in_port = 4'hF;
    ticks(12);
    bus_read(2'd3);
    check("t5_rise_any", rd_a, 32'h8);
    check("t5_rise_r", rd_r, 32'h8);
    bus_write(2'd3, 32'h8);
    in_port = 4'h7;
    ticks(12);
    bus_read(2'd3);
    check("t5_fall_any", rd_a, 32'h8);
    check("t5_fall_r", rd_r, 32'h0);

    // Reset in the middle of a debounce with edges pending and mask set.
    in_port = 4'hF;
    ticks(12);
    bus_write(2'd2, 32'hF);
    check("t6_irq_pending", {31'd0, irq_r}, 32'd1);
    in_port = 4'h7;
    ticks(7);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    check("t6_irq_r", {31'd0, irq_r}, 32'd0);
    check("t6_irq_a", {31'd0, irq_a}, 32'd0);
    check("t6_rdata", rd_r, 32'd0);
    bus_read(2'd0);
    check("t6_data", rd_r, 32'h0);
    check("t6_data_a", rd_a, 32'h5);
    bus_read(2'd2);
    check("t6_mask", rd_r, 32'h0);
    bus_read(2'd3);
    check("t6_cap", rd_r, 32'h0);
    ticks(6);
    bus_read(2'd0);
    check("t6_restart_e10", rd_r, 32'h0);
    bus_read(2'd0);
    check("t6_restart_e11", rd_r, 32'h7);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        tmp     = in_port;
        bit_sel = int'($urandom_range(0, 3));
        tmp[bit_sel] = ~tmp[bit_sel];
        in_port = tmp;
      end
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
